// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared state, opcode and ALUOp definitions for the multicycle MIPS controller
package mips_pkg;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JUMP    = 4'd11,
        S_HALT    = 4'd12
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

endpackage

// File: rtl/mips_mc_outdec.sv
// rtl/mips_mc_outdec.sv - Moore state-to-control decode for the multicycle MIPS controller
module mips_mc_outdec
    import mips_pkg::*;
(
    input  logic [3:0] state_i,
    output logic       iord_o,
    output logic       irwrite_o,
    output logic       memwrite_o,
    output logic       regwrite_o,
    output logic       regdst_o,
    output logic       memtoreg_o,
    output logic       alusrca_o,
    output logic [1:0] alusrcb_o,
    output logic [1:0] pcsrc_o,
    output logic [1:0] aluop_o,
    output logic       instrdone_o,
    output logic       pcwrite_o,
    output logic       branch_o
);

    always_comb begin
        iord_o      = 1'b0;
        irwrite_o   = 1'b0;
        memwrite_o  = 1'b0;
        regwrite_o  = 1'b0;
        regdst_o    = 1'b0;
        memtoreg_o  = 1'b0;
        alusrca_o   = 1'b0;
        alusrcb_o   = 2'b00;
        pcsrc_o     = 2'b00;
        aluop_o     = ALUOP_ADD;
        instrdone_o = 1'b0;
        pcwrite_o   = 1'b0;
        branch_o    = 1'b0;
        case (state_e'(state_i))
            S_FETCH: begin
                irwrite_o = 1'b1;
                pcwrite_o = 1'b1;
                alusrcb_o = 2'b01;
            end
            // DECODE precomputes the branch target into ALUOut.
            S_DECODE:  alusrcb_o = 2'b11;
            S_MEMADR: begin
                alusrca_o = 1'b1;
                alusrcb_o = 2'b10;
            end
            S_MEMRD:   iord_o = 1'b1;
            S_MEMWB: begin
                memtoreg_o  = 1'b1;
                regwrite_o  = 1'b1;
                instrdone_o = 1'b1;
            end
            S_MEMWR: begin
                iord_o      = 1'b1;
                memwrite_o  = 1'b1;
                instrdone_o = 1'b1;
            end
            S_EXECUTE: begin
                alusrca_o = 1'b1;
                aluop_o   = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                regdst_o    = 1'b1;
                regwrite_o  = 1'b1;
                instrdone_o = 1'b1;
            end
            S_BRANCH: begin
                alusrca_o   = 1'b1;
                aluop_o     = ALUOP_SUB;
                pcsrc_o     = 2'b01;
                branch_o    = 1'b1;
                instrdone_o = 1'b1;
            end
            S_ADDIEX: begin
                alusrca_o = 1'b1;
                alusrcb_o = 2'b10;
            end
            S_ADDIWB: begin
                regwrite_o  = 1'b1;
                instrdone_o = 1'b1;
            end
            S_JUMP: begin
                pcwrite_o   = 1'b1;
                pcsrc_o     = 2'b10;
                instrdone_o = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mips_mc_ctrl.sv
// rtl/mips_mc_ctrl.sv - multicycle MIPS control FSM: state register, next-state logic, reset gating
module mips_mc_ctrl
    import mips_pkg::*;
#(
    parameter bit HALT_ON_ILLEGAL = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] Opcode,
    input  logic       Zero,
    output logic       PCEn,
    output logic       IorD,
    output logic       IRWrite,
    output logic       MemWrite,
    output logic       RegWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] PCSrc,
    output logic [1:0] ALUOp,
    output logic       InstrDone,
    output logic [3:0] State
);

    state_e state_q, state_d;
    state_e dec_state;
    logic   irwrite_raw, memwrite_raw, regwrite_raw, instrdone_raw;
    logic   pcwrite, branch;

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (Opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXECUTE;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
                    default:      state_d = HALT_ON_ILLEGAL ? S_HALT : S_FETCH;
                endcase
            end
            S_MEMADR:  state_d = (Opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:   state_d = S_MEMWB;
            S_EXECUTE: state_d = S_ALUWB;
            S_ADDIEX:  state_d = S_ADDIWB;
            S_HALT:    state_d = S_HALT;
            default:   state_d = S_FETCH;
        endcase
    end

    // Under reset the non-write controls show their FETCH values even before state_q is known.
    assign dec_state = reset ? S_FETCH : state_q;

    mips_mc_outdec u_outdec (
        .state_i     (dec_state),
        .iord_o      (IorD),
        .irwrite_o   (irwrite_raw),
        .memwrite_o  (memwrite_raw),
        .regwrite_o  (regwrite_raw),
        .regdst_o    (RegDst),
        .memtoreg_o  (MemtoReg),
        .alusrca_o   (ALUSrcA),
        .alusrcb_o   (ALUSrcB),
        .pcsrc_o     (PCSrc),
        .aluop_o     (ALUOp),
        .instrdone_o (instrdone_raw),
        .pcwrite_o   (pcwrite),
        .branch_o    (branch)
    );

    assign IRWrite   = irwrite_raw   & ~reset;
    assign MemWrite  = memwrite_raw  & ~reset;
    assign RegWrite  = regwrite_raw  & ~reset;
    assign InstrDone = instrdone_raw & ~reset;
    assign PCEn      = (pcwrite | (branch & Zero)) & ~reset;
    assign State     = state_q;

endmodule

// File: doc/mips_mc_ctrl.md
MIPS_MC_CTRL -- requirements
Module: mips_mc_ctrl

Interface
REQ-001 Parameter: HALT_ON_ILLEGAL, default 0, 1 = unknown opcode parks FSM in HALT; 0 = unknown opcode returns to FETCH.
REQ-002 clk  in  1  rising-edge clock, sole clock domain.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 Opcode  in  6  instruction register bits [31:26].
REQ-005 Zero  in  1  ALU zero flag.
REQ-006 PCEn  out  1  PC load enable = PCWrite | (Branch & Zero).
REQ-007 IorD, IRWrite, MemWrite, RegWrite, RegDst, MemtoReg, ALUSrcA  out  1 each  datapath controls.
REQ-008 ALUSrcB  out  2  00 = reg B, 01 = constant 4, 10 = sign-extended immediate, 11 = immediate<<2.
REQ-009 PCSrc  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
REQ-010 ALUOp  out  2  00 = add, 01 = subtract, 10 = decode funct; feeds the ALU-control decoder.
REQ-011 InstrDone  out  1  one-cycle pulse in the final state of each instruction.
REQ-012 State  out  4  current state encoding, debug only.

Function
REQ-013 The block SHALL be a Moore FSM: every output except PCEn is decoded from the state register only.
REQ-014 States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTE, ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP, HALT.
REQ-015 Unlisted outputs SHALL be 0 in every state.
REQ-016 FETCH: IRWrite = 1, PCWrite = 1, ALUSrcB = 01, ALUOp = 00; next state DECODE.
REQ-017 DECODE: ALUSrcB = 11, ALUOp = 00. Opcode is sampled only in this state. Next state: 100011/101011 -> MEMADR; 000000 -> EXECUTE; 000100 -> BRANCH; 001000 -> ADDIEX; 000010 -> JUMP; else HALT if HALT_ON_ILLEGAL = 1, otherwise FETCH.
REQ-018 MEMADR: ALUSrcA = 1, ALUSrcB = 10; next state MEMRD for 100011, MEMWR for 101011. The opcode is held stable by the IR.
REQ-019 MEMRD: IorD = 1 -> MEMWB. MEMWB: MemtoReg = 1, RegWrite = 1, InstrDone = 1 -> FETCH.
REQ-020 MEMWR: IorD = 1, MemWrite = 1, InstrDone = 1 -> FETCH.
REQ-021 EXECUTE: ALUSrcA = 1, ALUSrcB = 00, ALUOp = 10 -> ALUWB. ALUWB: RegDst = 1, RegWrite = 1, InstrDone = 1 -> FETCH.
REQ-022 BRANCH: ALUSrcA = 1, ALUSrcB = 00, ALUOp = 01, PCSrc = 01, internal Branch = 1, InstrDone = 1 -> FETCH. PCEn = Zero in this state, combinationally in the same cycle.
REQ-023 ADDIEX: ALUSrcA = 1, ALUSrcB = 10 -> ADDIWB. ADDIWB: RegWrite = 1, InstrDone = 1 -> FETCH.
REQ-024 JUMP: PCWrite = 1, PCSrc = 10, InstrDone = 1 -> FETCH.
REQ-025 HALT: all outputs 0; exits only through reset.
REQ-026 Latency in cycles, FETCH inclusive: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.
REQ-027 Zero SHALL be ignored outside BRANCH. PCEn SHALL never assert in MEMWR/MEMWB/ALUWB/ADDIWB.

Reset
REQ-028 While reset = 1, on each rising edge the state register SHALL load FETCH.
REQ-029 While reset = 1, PCEn, IRWrite, MemWrite, RegWrite and InstrDone SHALL be forced 0 combinationally. All other outputs take their FETCH values.
REQ-030 Reset asserted mid-instruction (any state, including HALT) SHALL abandon that instruction with no write enable pulsed afterwards.
REQ-031 The first cycle after reset deasserts SHALL be FETCH.

Structure
REQ-032 Package mips_pkg SHALL hold the state enum, the opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J) and the ALUOp constants (ALUOP_ADD, ALUOP_SUB, ALUOP_FUNCT).
REQ-033 The state-to-output decode SHALL be one combinational sub-module, mips_mc_outdec. The next-state logic and the state register SHALL stay in mips_mc_ctrl.

Verification
REQ-034 Reset 3 cycles, then Opcode = 100011 -> states FETCH, DECODE, MEMADR, MEMRD, MEMWB; RegWrite = 1 and InstrDone = 1 only in cycle 5.
REQ-035 Opcode = 000100: with Zero = 1 -> PCEn = 1 in cycle 3 with PCSrc = 01 and ALUOp = 01; repeat with Zero = 0 -> PCEn = 0 in cycle 3.
REQ-036 Opcode = 000000 -> ALUOp = 10 in EXECUTE, then RegDst = 1 and RegWrite = 1 in ALUWB; sw (101011) -> MemWrite = 1 in cycle 4 only.
REQ-037 Opcode = 111111: with HALT_ON_ILLEGAL = 0 -> FETCH follows DECODE; with HALT_ON_ILLEGAL = 1 -> State = HALT held for 20 cycles, all outputs 0, until reset.
REQ-038 Assert reset while in MEMRD -> next state FETCH, RegWrite never asserts. Toggle Zero every cycle during a j (000010) -> PCEn asserts only in FETCH and JUMP.
